// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic tile controller.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_STREAM,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } ctrl_state_e;

    localparam int DEFAULT_N              = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;
    localparam int DEFAULT_CNT_WIDTH      = 16;

    // Results need one full diagonal sweep of the array to settle.
    function automatic int default_drain_cycles(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/systolic_last_tracker.sv
// Sticky per-channel record of queue "last" pulses. all_seen_o already
// includes a pulse arriving this cycle, so completion is recognised in the
// same cycle as the final pulse.
module systolic_last_tracker #(
    parameter int N = 8
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clear_i,
    input  logic         capture_i,
    input  logic [N-1:0] last_i,
    output logic         all_seen_o
);

    logic [N-1:0] mask_q;
    logic [N-1:0] seen;

    assign seen       = capture_i ? (mask_q | last_i) : mask_q;
    assign all_seen_o = &seen;

    // Accumulate pulses while capturing; a clear empties the mask for a new pass.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mask_q <= '0;
        end else if (clear_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= seen;
        end
    end

endmodule

// File: rtl/systolic_tile_controller.sv
// Sequences one matrix-multiply pass through the systolic array.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | waiting for start_i
//   S_CLEAR  | one cycle: clear PE accumulators, last masks, cycle counter
//   S_LAUNCH | one cycle: start row and column queues together
//   S_STREAM | queues feeding the array; wait for every last + both empty
//   S_DRAIN  | DRAIN_CYCLES cycles for the final data to ripple through
//   S_DONE   | one cycle: results valid, cycle count latched
//   S_ERROR  | watchdog expired; held until abort_i
module systolic_tile_controller
    import systolic_pkg::*;
#(
    parameter int N              = DEFAULT_N,
    parameter int DRAIN_CYCLES   = default_drain_cycles(N),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    output logic                 row_start_o,
    output logic                 col_start_o,
    input  logic [N-1:0]         row_last_i,
    input  logic [N-1:0]         col_last_i,
    input  logic                 row_empty_i,
    input  logic                 col_empty_i,
    output logic                 pe_clear_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o
);

    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    if (DRAIN_CYCLES < 1) begin : g_bad_drain
        $error("DRAIN_CYCLES must be >= 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    ctrl_state_e          state_q, state_d;
    logic [DW-1:0]        drain_cnt_q;
    logic [TW-1:0]        wd_cnt_q;
    logic [CNT_WIDTH-1:0] cyc_cnt_q;
    logic [CNT_WIDTH-1:0] cyc_inc;
    logic                 capture;
    logic                 row_all, col_all;
    logic                 stream_done;

    assign capture     = (state_q == S_LAUNCH) || (state_q == S_STREAM);
    assign stream_done = row_all && col_all && row_empty_i && col_empty_i;
    assign cyc_inc     = (&cyc_cnt_q) ? cyc_cnt_q : cyc_cnt_q + CNT_WIDTH'(1);

    systolic_last_tracker #(.N(N)) u_row_tracker (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clear_i    (state_q == S_CLEAR),
        .capture_i  (capture),
        .last_i     (row_last_i),
        .all_seen_o (row_all)
    );

    systolic_last_tracker #(.N(N)) u_col_tracker (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .clear_i    (state_q == S_CLEAR),
        .capture_i  (capture),
        .last_i     (col_last_i),
        .all_seen_o (col_all)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i && !abort_i) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_STREAM;
            S_STREAM: begin
                if (stream_done) begin
                    state_d = S_DRAIN;
                end else if (wd_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                end
            end
            S_DRAIN:  if (drain_cnt_q == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    // Watchdog, drain timer and pass cycle counter.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wd_cnt_q      <= '0;
            drain_cnt_q   <= '0;
            cyc_cnt_q     <= '0;
            cycle_count_o <= '0;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    wd_cnt_q      <= '0;
                    cyc_cnt_q     <= '0;
                    cycle_count_o <= '0;
                end
                S_LAUNCH: cyc_cnt_q <= cyc_inc;
                S_STREAM: begin
                    wd_cnt_q    <= wd_cnt_q + TW'(1);
                    cyc_cnt_q   <= cyc_inc;
                    // Preloaded every STREAM cycle so it is ready on DRAIN entry.
                    drain_cnt_q <= DW'(DRAIN_CYCLES - 1);
                end
                S_DRAIN: begin
                    cyc_cnt_q <= cyc_inc;
                    if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - DW'(1);
                end
                S_DONE:  cycle_count_o <= cyc_inc;
                default: ;
            endcase
        end
    end

    // Outputs registered from the next state so they change with the state itself.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pe_clear_o  <= 1'b0;
            row_start_o <= 1'b0;
            col_start_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            pe_clear_o  <= (state_d == S_CLEAR);
            row_start_o <= (state_d == S_LAUNCH);
            col_start_o <= (state_d == S_LAUNCH);
            busy_o      <= (state_d != S_IDLE);
            done_o      <= (state_d == S_DONE);
            error_o     <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_systolic_tile_controller.sv
// Scoreboard bench for systolic_tile_controller (N=4, DRAIN=8, TIMEOUT=64).
module tb_systolic_tile_controller;

    localparam int N  = 4;
    localparam int CW = 16;

    localparam int EV_CLEAR = 0;
    localparam int EV_START = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_ERROR = 3;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic          row_start_o, col_start_o;
    logic [N-1:0]  row_last_i = '0;
    logic [N-1:0]  col_last_i = '0;
    logic          row_empty_i = 1'b1;
    logic          col_empty_i = 1'b1;
    logic          pe_clear_o, busy_o, done_o, error_o;
    logic [CW-1:0] cycle_count_o;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    logic done_pend = 1'b0;
    int   done_cyc  = 0;
    logic err_prev  = 1'b0;

    systolic_tile_controller #(
        .N(N), .DRAIN_CYCLES(8), .TIMEOUT_CYCLES(64), .CNT_WIDTH(CW)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .row_start_o   (row_start_o),
        .col_start_o   (col_start_o),
        .row_last_i    (row_last_i),
        .col_last_i    (col_last_i),
        .row_empty_i   (row_empty_i),
        .col_empty_i   (col_empty_i),
        .pe_clear_o    (pe_clear_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .cycle_count_o (cycle_count_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic log_event(input int kind, input int c, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d value=%0d expected=none", kind, c, val);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_cycle", c, e.cyc);
            check("ev_value", val, e.val);
        end
    endtask

    // Monitor: turns DUT output activity into events and scores them.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            done_pend = 1'b0;
            err_prev  = 1'b0;
        end else begin
            if (done_pend) begin
                log_event(EV_DONE, done_cyc, int'(cycle_count_o));
                done_pend = 1'b0;
            end
            if (pe_clear_o) log_event(EV_CLEAR, cyc, 0);
            if (row_start_o || col_start_o) log_event(EV_START, cyc, int'({row_start_o, col_start_o}));
            if (done_o) begin
                done_pend = 1'b1;
                done_cyc  = cyc;
            end
            if (error_o && !err_prev) log_event(EV_ERROR, cyc, 0);
            err_prev = error_o;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic queue_empty(input string name);
        check(name, exp_q.size(), 0);
    endtask

    // Lasts on rows then columns, plus start held during DRAIN and DONE (ignored).
    task automatic nominal_pass();
        int t;
        t = cyc + 1;
        push(EV_CLEAR, t + 1, 0);
        push(EV_START, t + 2, 3);
        push(EV_DONE, t + 13, 12);
        wait_cyc(t);      start_i = 1'b1;
        wait_cyc(t + 1);  start_i = 1'b0;
        wait_cyc(t + 3);  row_last_i = '1;
        wait_cyc(t + 4);  row_last_i = '0; col_last_i = '1;
        wait_cyc(t + 5);  col_last_i = '0; check("nom_busy_drain", busy_o, 1); start_i = 1'b1;
        wait_cyc(t + 7);  start_i = 1'b0;
        wait_cyc(t + 13); start_i = 1'b1;
        wait_cyc(t + 14); start_i = 1'b0; check("nom_busy_after", busy_o, 0);
        wait_cyc(t + 17); check("nom_idle_after_start_in_done", busy_o, 0);
        queue_empty("nom_queue");
    endtask

    initial begin
        int t;
        fork
            begin
                #100000;
                $display("FAIL global_timeout expected=finish actual=hung");
                $fatal(1, "bench timeout");
            end
        join_none

        // Reset
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_clear", pe_clear_o, 0);
        check("rst_starts", int'({row_start_o, col_start_o}), 0);
        check("rst_count", int'(cycle_count_o), 0);
        rstn_i = 1'b1;

        // Nominal pass
        nominal_pass();

        // Staggered lasts, column lasts captured in LAUNCH, duplicate row pulse
        t = cyc + 1;
        push(EV_CLEAR, t + 1, 0);
        push(EV_START, t + 2, 3);
        push(EV_DONE, t + 29, 28);
        wait_cyc(t);      start_i = 1'b1;
        wait_cyc(t + 1);  start_i = 1'b0;
        wait_cyc(t + 2);  col_last_i = 4'b0111;
        wait_cyc(t + 3);  col_last_i = '0;
        wait_cyc(t + 5);  row_last_i = 4'b0001;
        wait_cyc(t + 6);  row_last_i = 4'b0010;
        wait_cyc(t + 7);  row_last_i = 4'b0100;
        wait_cyc(t + 8);  row_last_i = 4'b1000;
        wait_cyc(t + 9);  row_last_i = '0;
        wait_cyc(t + 10); row_last_i = 4'b0010;
        wait_cyc(t + 11); row_last_i = '0;
        wait_cyc(t + 20); col_last_i = 4'b1000;
        wait_cyc(t + 21); col_last_i = '0; check("stag_busy", busy_o, 1);
        wait_cyc(t + 33); queue_empty("stag_queue");

        // Queue not empty holds off DRAIN
        t = cyc + 1;
        push(EV_CLEAR, t + 1, 0);
        push(EV_START, t + 2, 3);
        push(EV_DONE, t + 18, 17);
        wait_cyc(t);      start_i = 1'b1; row_empty_i = 1'b0;
        wait_cyc(t + 1);  start_i = 1'b0;
        wait_cyc(t + 3);  row_last_i = '1; col_last_i = '1;
        wait_cyc(t + 4);  row_last_i = '0; col_last_i = '0;
        wait_cyc(t + 9);  row_empty_i = 1'b1;
        wait_cyc(t + 22); queue_empty("empty_queue");

        // Watchdog timeout with col channel 2 withheld
        t = cyc + 1;
        push(EV_CLEAR, t + 1, 0);
        push(EV_START, t + 2, 3);
        push(EV_ERROR, t + 67, 0);
        wait_cyc(t);      start_i = 1'b1;
        wait_cyc(t + 1);  start_i = 1'b0;
        wait_cyc(t + 3);  row_last_i = '1; col_last_i = 4'b1011;
        wait_cyc(t + 4);  row_last_i = '0; col_last_i = '0;
        wait_cyc(t + 70);
        check("to_error_held", error_o, 1);
        check("to_busy_held", busy_o, 1);
        abort_i = 1'b1;
        wait_cyc(t + 71); abort_i = 1'b0;
        check("to_error_cleared", error_o, 0);
        check("to_busy_cleared", busy_o, 0);
        wait_cyc(t + 72); queue_empty("to_queue");

        // Abort in the third DRAIN cycle
        t = cyc + 1;
        push(EV_CLEAR, t + 1, 0);
        push(EV_START, t + 2, 3);
        wait_cyc(t);      start_i = 1'b1;
        wait_cyc(t + 1);  start_i = 1'b0;
        wait_cyc(t + 3);  row_last_i = '1; col_last_i = '1;
        wait_cyc(t + 4);  row_last_i = '0; col_last_i = '0;
        wait_cyc(t + 6);  check("ab_busy_drain", busy_o, 1); abort_i = 1'b1;
        wait_cyc(t + 7);  abort_i = 1'b0; check("ab_busy_idle", busy_o, 0);
        wait_cyc(t + 20); queue_empty("ab_queue");

        // start together with abort in IDLE is ignored
        t = cyc + 1;
        wait_cyc(t);      start_i = 1'b1; abort_i = 1'b1;
        wait_cyc(t + 1);  start_i = 1'b0; abort_i = 1'b0;
        wait_cyc(t + 4);  check("sa_busy", busy_o, 0);
        queue_empty("sa_queue");

        // Reset in the middle of STREAM, then a fresh nominal pass
        t = cyc + 1;
        push(EV_CLEAR, t + 1, 0);
        push(EV_START, t + 2, 3);
        wait_cyc(t);      start_i = 1'b1;
        wait_cyc(t + 1);  start_i = 1'b0;
        wait_cyc(t + 3);  row_last_i = '1;
        wait_cyc(t + 4);  row_last_i = '0; check("rs_busy_stream", busy_o, 1);
        wait_cyc(t + 5);  #2; rstn_i = 1'b0; #1;
        check("rs_busy", busy_o, 0);
        check("rs_outputs", int'({row_start_o, col_start_o, pe_clear_o, done_o, error_o}), 0);
        check("rs_count", int'(cycle_count_o), 0);
        wait_cyc(t + 7);  rstn_i = 1'b1;
        queue_empty("rs_queue");
        nominal_pass();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
